// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one immediate-extension unit feeding a one-entry result register
// Ports: clk_i/rst_i (async active-low); req0_*/req1_* valid/ready/data/mode/tag requesters;
// res_* valid/ready result with src (0=req0, 1=req1) and tag.
// Optional IMM_EXT_PERF_EN: perf_grant0_o, perf_grant1_o, perf_stall_o saturating 16-bit counters.
module imm_ext_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [IN_W-1:0]  req0_data_i,
  input  logic [1:0]       req0_mode_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [IN_W-1:0]  req1_data_i,
  input  logic [1:0]       req1_mode_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [OUT_W-1:0] res_data_o,
  output logic             res_src_o,
  output logic [TAG_W-1:0] res_tag_o
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [15:0]      perf_grant0_o,
  output logic [15:0]      perf_grant1_o,
  output logic [15:0]      perf_stall_o
`endif
);
  localparam int EW = OUT_W - IN_W;
  logic             valid_q, valid_d, src_q, src_d, last_q, last_d;
  logic [OUT_W-1:0] data_q, data_d, sx, zx, ext;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IN_W-1:0]  x;
  logic [1:0]       m;
  logic             slot_free, g0, g1;
  // req1 wins when alone, or when both are valid and req0 was granted last
  always_comb begin
    slot_free = !valid_q || res_ready_i;
    g1 = slot_free && req1_valid_i && (!req0_valid_i || !last_q);
    g0 = slot_free && req0_valid_i && !g1;
    x  = g1 ? req1_data_i : req0_data_i;
    m  = g1 ? req1_mode_i : req0_mode_i;
    sx = {{EW{x[IN_W-1]}}, x};
    zx = {{EW{1'b0}}, x};
    ext = m == 2'd0 ? sx : m == 2'd1 ? zx : m == 2'd2 ? {x, {EW{1'b0}}} : sx << 2;
    valid_d = (g0 || g1) ? 1'b1 : res_ready_i ? 1'b0 : valid_q;
    data_d  = (g0 || g1) ? ext : data_q;
    src_d   = (g0 || g1) ? g1 : src_q;
    tag_d   = g1 ? req1_tag_i : g0 ? req0_tag_i : tag_q;
    last_d  = (g0 || g1) ? g1 : last_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end
  assign req0_ready_o = g0;
  assign req1_ready_o = g1;
  assign res_valid_o  = valid_q;
  assign res_data_o   = data_q;
  assign res_src_o    = src_q;
  assign res_tag_o    = tag_q;
`ifdef IMM_EXT_PERF_EN
  logic [15:0] pg0_q, pg0_d, pg1_q, pg1_d, pst_q, pst_d;
  always_comb begin
    pg0_d = (g0 && pg0_q != 16'hFFFF) ? pg0_q + 16'd1 : pg0_q;
    pg1_d = (g1 && pg1_q != 16'hFFFF) ? pg1_q + 16'd1 : pg1_q;
    pst_d = (valid_q && !res_ready_i && pst_q != 16'hFFFF) ? pst_q + 16'd1 : pst_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pst_q <= '0;
    end else begin
      pg0_q <= pg0_d;
      pg1_q <= pg1_d;
      pst_q <= pst_d;
    end
  end
  assign perf_grant0_o = pg0_q;
  assign perf_grant1_o = pg1_q;
  assign perf_stall_o  = pst_q;
`endif
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed and randomized checks of imm_ext_arbiter against a transaction-level model
module tb_imm_ext_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic v0 = 0, v1 = 0, rdy0, rdy1, res_valid, res_ready = 0, res_src;
  logic [15:0] d0 = 0, d1 = 0;
  logic [1:0] m0 = 0, m1 = 0;
  logic [3:0] t0 = 0, t1 = 0, res_tag;
  logic [31:0] res_data;
`ifdef IMM_EXT_PERF_EN
  logic [15:0] pg0, pg1, pst;
`endif
  imm_ext_arbiter dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_data_i(d0), .req0_mode_i(m0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_data_i(d1), .req1_mode_i(m1), .req1_tag_i(t1),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_src_o(res_src), .res_tag_o(res_tag)
`ifdef IMM_EXT_PERF_EN
    , .perf_grant0_o(pg0), .perf_grant1_o(pg1), .perf_stall_o(pst)
`endif
  );
  int total = 0, bad = 0;
  bit e_valid, e_src, e_last, acc0, acc1;
  logic [31:0] e_data;
  logic [3:0] e_tag;
  int n_g0, n_g1, n_st;
  logic [31:0] mode_exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ext(input logic [15:0] x, input logic [1:0] m);
    longint s = longint'($signed(x));
    longint u = longint'(x);
    case (m)
      2'd0: return 32'(s);
      2'd1: return 32'(u);
      2'd2: return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction
  task automatic model_reset();
    e_valid = 0; e_data = 0; e_src = 0; e_tag = 0; e_last = 1;
    n_g0 = 0; n_g1 = 0; n_st = 0; acc0 = 0; acc1 = 0;
  endtask
  task automatic step();
    bit free, g0, g1;
    #1;
    free = !e_valid || res_ready;
    g0 = free && v0 && (!v1 || e_last);
    g1 = free && v1 && (!v0 || !e_last);
    chk("rdy0", 32'(rdy0), 32'(g0));
    chk("rdy1", 32'(rdy1), 32'(g1));
    if (e_valid && !res_ready) n_st++;
    @(posedge clk);
    if (g0 || g1) begin
      e_valid = 1; e_src = g1; e_last = g1;
      e_data = g1 ? ext(d1, m1) : ext(d0, m0);
      e_tag = g1 ? t1 : t0;
      if (g1) n_g1++; else n_g0++;
    end else if (res_ready) e_valid = 0;
    acc0 = g0; acc1 = g1;
    #1;
    chk("valid", 32'(res_valid), 32'(e_valid));
    chk("data", res_data, e_data);
    chk("src", 32'(res_src), 32'(e_src));
    chk("tag", 32'(res_tag), 32'(e_tag));
  endtask
  task automatic refresh();
    if (!v0 || acc0) begin
      v0 = 1'($urandom_range(0, 1)); d0 = 16'($urandom); m0 = 2'($urandom); t0 = 4'($urandom);
    end
    if (!v1 || acc1) begin
      v1 = 1'($urandom_range(0, 1)); d1 = 16'($urandom); m1 = 2'($urandom); t1 = 4'($urandom);
    end
    res_ready = $urandom_range(0, 3) != 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", res_data, 0);
    rst_n = 1;
    v0 = 1; v1 = 1; res_ready = 1; t0 = 4'h3; t1 = 4'hC;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_src", 32'(res_src), 32'(i % 2));
    end
    res_ready = 0;
    for (int i = 0; i < 3; i++) step();
    res_ready = 1;
    step();
    v0 = 0; v1 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_src", 32'(res_src), 1);
    end
    v0 = 1;
    step();
    chk("after_single", 32'(res_src), 0);
    v1 = 0; d0 = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      m0 = 2'(i);
      step();
      chk("mode", res_data, mode_exp[i]);
    end
    for (int i = 0; i < 400; i++) begin
      refresh();
      step();
    end
    v0 = 1; v1 = 1; res_ready = 0;
    step();
    #2 rst_n = 0;
    #1 chk("async_rst", 32'(res_valid), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    res_ready = 1;
    step();
    chk("post_rst_src", 32'(res_src), 0);
    for (int i = 0; i < 200; i++) begin
      refresh();
      step();
    end
`ifdef IMM_EXT_PERF_EN
    chk("perf_g0", 32'(pg0), 32'(n_g0));
    chk("perf_g1", 32'(pg1), 32'(n_g1));
    chk("perf_st", 32'(pst), 32'(n_st));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
